ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: transmit FSM states, protocol constants and
// a helper for sizing saturating counters.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam int INHIBIT_US  = 100;
  localparam int FRAME_EDGES = 11;

  // Width holding 0..limit-1; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe.
// Flops reset high so an idle bus does not produce a spurious edge after reset.
module ps2_line_sync (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_sync = sync_q;
  assign fall      = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-edge frame, ACK).
// Define PS2_HOST_TX_TIMEOUT_EN to build the request-to-send-to-ACK watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_KHZ    = 52000,
  parameter int TIMEOUT_MS = 20
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       tx_busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INHIBIT_CYC = CLK_KHZ * INHIBIT_US / 1000;
  localparam int INH_W       = cnt_width(INHIBIT_CYC);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [3:0] PARITY_EDGE = 4'(FRAME_EDGES - 2);

  ps2_state_t       state, state_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [INH_W-1:0] inh_cnt;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             ack_ok_q, ack_ok_next;
  logic             done_q, done_next;
  logic             error_q, error_next;
  logic             load;
  logic             wd_expired;

  logic clk_sync, clk_fall;
  logic dat_sync, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .fall      (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .line_in   (ps2_dat_in),
    .line_sync (dat_sync),
    .fall      (dat_fall_unused)
  );

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_LIMIT = CLK_KHZ * TIMEOUT_MS;
  localparam int WD_W     = cnt_width(WD_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;

  assign wd_run     = (state == RTS) || (state == DATA) || (state == ACK);
  assign wd_expired = wd_run && (wd_cnt == WD_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (!wd_run) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LAST) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  localparam int wd_limit_unused = CLK_KHZ * TIMEOUT_MS;
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      inh_cnt <= '0;
    end else if (state != INHIBIT) begin
      inh_cnt <= '0;
    end else if (inh_cnt != INH_LAST) begin
      inh_cnt <= inh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      parity_q <= 1'b0;
    end else if (load) begin
      data_q   <= tx_data;
      parity_q <= ~^tx_data;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      ack_ok_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      ack_ok_q <= ack_ok_next;
      done_q   <= done_next;
      error_q  <= error_next;
    end
  end

  // bit_cnt counts device falling edges seen in the frame; edge k drives bit k-1.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    ack_ok_next  = ack_ok_q;
    done_next    = 1'b0;
    error_next   = 1'b0;
    load         = 1'b0;
    ps2_clk_oe   = 1'b0;
    ps2_dat_oe   = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_next = '0;
        if (tx_valid) begin
          load        = 1'b1;
          ack_ok_next = 1'b0;
          state_next  = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == INH_LAST) state_next = RTS;
      end
      RTS: begin
        ps2_dat_oe = 1'b1;
        if (clk_fall) begin
          bit_cnt_next = 4'd1;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_cnt == PARITY_EDGE) ps2_dat_oe = ~parity_q;
        else                        ps2_dat_oe = ~data_q[3'(bit_cnt - 4'd1)];
        if (clk_fall) begin
          bit_cnt_next = bit_cnt + 4'd1;
          if (bit_cnt == PARITY_EDGE) state_next = ACK;
        end
      end
      ACK: begin
        if (clk_fall) begin
          bit_cnt_next = 4'(FRAME_EDGES);
          state_next   = WAIT_IDLE;
          if (dat_sync) error_next  = 1'b1;
          else          ack_ok_next = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_next = IDLE;
          done_next  = ack_ok_q;
        end
      end
      default: state_next = IDLE;
    endcase

    if (wd_expired) begin
      state_next = IDLE;
      error_next = 1'b1;
      done_next  = 1'b0;
    end
  end

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign tx_done  = done_q;
  assign tx_error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model and a frame reference model.
// Honours PS2_HOST_TX_TIMEOUT_EN for the silent-device scenario.
module tb_ps2_host_tx;

  localparam int CLK_KHZ     = 4000;
  localparam int TIMEOUT_MS  = 1;
  localparam int INHIBIT_CYC = CLK_KHZ * 100 / 1000;
  localparam int WD_LIMIT    = CLK_KHZ * TIMEOUT_MS;
  localparam int HALF        = 20;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, tx_busy;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_pull = 1'b0;
  logic       dev_dat_pull = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int frame_cnt = 0;
  logic clk_oe_d = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_pull);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_pull);

  always #5 clk_sys = ~clk_sys;

  ps2_host_tx #(
    .CLK_KHZ    (CLK_KHZ),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .tx_busy    (tx_busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  // Pulse and frame-start counters observed away from the active edge.
  always @(negedge clk_sys) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
    if (tx_done === 1'b1 && tx_error === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if (ps2_clk_oe === 1'b1 && clk_oe_d === 1'b0) frame_cnt <= frame_cnt + 1;
    clk_oe_d <= ps2_clk_oe;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout simulation exceeded its time limit");
    $fatal(1, "[TB] global timeout");
  end

  // Line levels of one frame, first-sent bit at index 0: data LSB first, odd parity, stop.
  function automatic logic [9:0] expected_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 5000) begin
      @(negedge clk_sys);
      t++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk_sys);
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 5000) begin
      @(negedge clk_sys);
      t++;
    end
    ok = (tx_ready === 1'b1);
    repeat (2) @(negedge clk_sys);
  endtask

  // Device side: waits for request-to-send, clocks 11 edges, samples on rising edges.
  task automatic device_frame(input bit ack_low, input int abort_edge,
                              output logic [9:0] line_bits, output bit started);
    int t;
    line_bits = '0;
    started   = 1'b0;
    t = 0;
    while (!(ps2_dat_oe === 1'b1 && ps2_clk_oe === 1'b0) && t < 20000) begin
      @(negedge clk_sys);
      t++;
    end
    if (t >= 20000) return;
    started = 1'b1;
    repeat (HALF) @(negedge clk_sys);
    for (int k = 1; k <= 11; k++) begin
      dev_clk_pull = 1'b1;
      if (k == abort_edge) begin
        repeat (6) @(negedge clk_sys);
        return;
      end
      repeat (HALF) @(negedge clk_sys);
      if (k <= 10) line_bits[k-1] = ps2_dat_in;
      dev_clk_pull = 1'b0;
      if (k == 10 && ack_low) dev_dat_pull = 1'b1;
      repeat (HALF) @(negedge clk_sys);
    end
    dev_dat_pull = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks += 6;
    if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", tx_ready); end
    if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", tx_busy); end
    if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", tx_done); end
    if (tx_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b want 0", tx_error); end
    if (ps2_clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
    if (ps2_dat_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_dat_oe got %b want 0", ps2_dat_oe); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic test_frame_ed();
    logic [9:0] bits;
    bit started, ok;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hED);
    device_frame(1'b1, 0, bits, started);
    wait_ready(ok);
    checks += 4;
    if (bits !== expected_frame(8'hED)) begin
      errors++; $display("[TB] FAIL ed_frame line bits got %b want %b", bits, expected_frame(8'hED));
    end
    if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL ed_done pulses got %0d want 1", done_cnt - d0); end
    if (err_cnt - e0 != 0) begin errors++; $display("[TB] FAIL ed_error pulses got %0d want 0", err_cnt - e0); end
    if (!ok) begin errors++; $display("[TB] FAIL ed_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_inhibit_f4();
    logic [9:0] bits;
    bit started, ok;
    int inh, dat_bad, d0;
    d0 = done_cnt;
    send_byte(8'hF4);
    inh = 0; dat_bad = 0;
    while (ps2_clk_oe === 1'b1 && inh < 4 * INHIBIT_CYC) begin
      if (ps2_dat_oe !== 1'b0) dat_bad++;
      inh++;
      @(negedge clk_sys);
    end
    device_frame(1'b1, 0, bits, started);
    wait_ready(ok);
    checks += 4;
    if (inh != INHIBIT_CYC) begin errors++; $display("[TB] FAIL inhibit_len got %0d want %0d", inh, INHIBIT_CYC); end
    if (dat_bad != 0) begin errors++; $display("[TB] FAIL inhibit_dat_oe got %0d cycles high want 0", dat_bad); end
    if (bits !== expected_frame(8'hF4)) begin
      errors++; $display("[TB] FAIL f4_frame line bits got %b want %b", bits, expected_frame(8'hF4));
    end
    if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL f4_done pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_random_frames();
    logic [9:0] bits;
    logic [7:0] b;
    bit started, ok;
    int d0, e0;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      d0 = done_cnt; e0 = err_cnt;
      send_byte(b);
      device_frame(1'b1, 0, bits, started);
      wait_ready(ok);
      checks += 3;
      if (bits !== expected_frame(b)) begin
        errors++; $display("[TB] FAIL rand_frame data %h got %b want %b", b, bits, expected_frame(b));
      end
      if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL rand_done data %h got %0d want 1", b, done_cnt - d0); end
      if (err_cnt - e0 != 0) begin errors++; $display("[TB] FAIL rand_error data %h got %0d want 0", b, err_cnt - e0); end
    end
  endtask

  task automatic test_no_ack();
    logic [9:0] bits;
    bit started, ok;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h3E);
    device_frame(1'b0, 0, bits, started);
    wait_ready(ok);
    checks += 3;
    if (err_cnt - e0 != 1) begin errors++; $display("[TB] FAIL noack_error got %0d want 1", err_cnt - e0); end
    if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL noack_done got %0d want 0", done_cnt - d0); end
    if (!ok) begin errors++; $display("[TB] FAIL noack_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_timeout();
    int t, rts, e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    send_byte(8'h42);
    t = 0;
    while (ps2_clk_oe === 1'b1 && t < 4 * INHIBIT_CYC) begin @(negedge clk_sys); t++; end
`ifdef PS2_HOST_TX_TIMEOUT_EN
    rts = 0;
    while (ps2_dat_oe === 1'b1 && ps2_clk_oe === 1'b0 && rts < 2 * WD_LIMIT) begin
      @(negedge clk_sys); rts++;
    end
    checks += 5;
    if (rts != WD_LIMIT) begin errors++; $display("[TB] FAIL timeout_len got %0d want %0d", rts, WD_LIMIT); end
    if (tx_error !== 1'b1) begin errors++; $display("[TB] FAIL timeout_error got %b want 1", tx_error); end
    if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL timeout_ready got %b want 1", tx_ready); end
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_oe got %b%b want 00", ps2_clk_oe, ps2_dat_oe);
    end
    repeat (2) @(negedge clk_sys);
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      errors++; $display("[TB] FAIL timeout_pulses got err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
`else
    rts = 0;
    repeat (WD_LIMIT + 100) @(negedge clk_sys);
    checks += 3;
    if (tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_busy got busy %b ready %b want 1 0", tx_busy, tx_ready);
    end
    if (ps2_dat_oe !== 1'b1 || ps2_clk_oe !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_oe got clk %b dat %b want 0 1", ps2_clk_oe, ps2_dat_oe);
    end
    if (err_cnt - e0 != rts) begin errors++; $display("[TB] FAIL stall_error got %0d want 0", err_cnt - e0); end
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
`endif
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    bit started, ok;
    int d0;
    send_byte(8'h55);
    device_frame(1'b1, 5, bits, started);
    checks += 4;
    if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL midframe_busy got %b want 1", tx_busy); end
    #1 reset_n = 1'b0;
    #1;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset_oe got %b%b want 00", ps2_clk_oe, ps2_dat_oe);
    end
    if (tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL async_reset_state got busy %b ready %b want 0 1", tx_busy, tx_ready);
    end
    if (tx_done !== 1'b0 || tx_error !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset_pulses got %b%b want 00", tx_done, tx_error);
    end
    dev_clk_pull = 1'b0;
    dev_dat_pull = 1'b0;
    repeat (4) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    d0 = done_cnt;
    send_byte(8'hAA);
    device_frame(1'b1, 0, bits, started);
    wait_ready(ok);
    checks += 2;
    if (bits !== expected_frame(8'hAA)) begin
      errors++; $display("[TB] FAIL aa_frame line bits got %b want %b", bits, expected_frame(8'hAA));
    end
    if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL aa_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    logic [7:0] b;
    bit started, ok;
    int f0, d0;
    b = 8'($urandom_range(0, 255));
    f0 = frame_cnt; d0 = done_cnt;
    send_byte(b);
    fork
      device_frame(1'b1, 0, bits, started);
      begin
        for (int p = 0; p < 6; p++) begin
          repeat (100) @(negedge clk_sys);
          tx_data  = 8'($urandom_range(0, 255));
          tx_valid = 1'b1;
          @(negedge clk_sys);
          tx_valid = 1'b0;
        end
      end
    join
    wait_ready(ok);
    repeat (2 * INHIBIT_CYC) @(negedge clk_sys);
    checks += 4;
    if (bits !== expected_frame(b)) begin
      errors++; $display("[TB] FAIL b2b_frame data %h got %b want %b", b, bits, expected_frame(b));
    end
    if (frame_cnt - f0 != 1) begin errors++; $display("[TB] FAIL b2b_frames got %0d want 1", frame_cnt - f0); end
    if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL b2b_done got %0d want 1", done_cnt - d0); end
    if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle got ready %b want 1", tx_ready); end
  endtask

  task automatic test_exclusive_pulses();
    checks++;
    if (overlap_cnt != 0) begin
      errors++; $display("[TB] FAIL done_error_overlap got %0d cycles want 0", overlap_cnt);
    end
  endtask

  initial begin
    @(negedge clk_sys);
    test_reset();
    test_frame_ed();
    test_inhibit_f4();
    test_random_frames();
    test_no_ack();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    test_exclusive_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
